// File: rtl/keypad_input_port_if.sv
// Keypad input port bus: raw buttons and CPU read strobe in; read data, valid and
// overflow flags out.
//   keys_n   : raw active-low buttons (asynchronous to clk)
//   rd       : CPU read strobe, one cycle = one pop
//   d_out    : {valid, overflow, 10'b0, key_idx[3:0]}
//   valid    : event FIFO non-empty
//   overflow : sticky, an event was dropped
// master = CPU/board side, slave = keypad port.
interface keypad_input_port_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] keys_n;
  logic              rd;
  logic [15:0]       d_out;
  logic              valid;
  logic              overflow;

  modport master (
    output keys_n,
    output rd,
    input  d_out,
    input  valid,
    input  overflow
  );

  modport slave (
    input  keys_n,
    input  rd,
    output d_out,
    output valid,
    output overflow
  );
endinterface

// File: rtl/keypad_input_port.sv
// Keypad input port: synchronises and debounces N_KEYS active-low buttons, turns each
// debounced press into a key-index event and queues events in a small FIFO that the CPU
// pops one entry per read strobe.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : keypad_input_port_if slave (keys_n, rd in; d_out, valid, overflow out)
module keypad_input_port #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic                 clk,
  input logic                 reset,
  keypad_input_port_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  // Synchroniser and debounce state
  logic [N_KEYS-1:0] sync1_q, sync_q;
  logic [N_KEYS-1:0] stable_q, stable_d;
  logic [CW-1:0]     cnt_q [N_KEYS];
  logic [CW-1:0]     cnt_d [N_KEYS];
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] press_set;

  // Encoder
  logic              push;
  logic [3:0]        push_idx;
  logic [N_KEYS-1:0] push_clr;

  // FIFO
  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        overflow_q, overflow_d;
  logic        empty, full, do_pop, do_push, drop;

  always_comb begin
    stable_d  = stable_q;
    press_set = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CntMax) begin
        stable_d[k] = sync_q[k];
        cnt_d[k]    = '0;
        press_set[k] = ~sync_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Lowest pending index wins; iterate downwards so the lowest assignment sticks.
  always_comb begin
    push     = |pending_q;
    push_idx = '0;
    push_clr = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        push_idx = 4'(k);
      end
    end
    if (push) begin
      push_clr[push_idx] = 1'b1;
    end
    // A press landing on the same edge as its clear must survive.
    pending_d = (pending_q & ~push_clr) | press_set;
  end

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = bus.rd && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !bus.rd;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.rd) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '1;
      sync_q     <= '1;
      stable_q   <= '1;
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q    <= bus.keys_n;
      sync_q     <= sync1_q;
      stable_q   <= stable_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < N_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: valid masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= push_idx;
    end
  end

  assign bus.valid    = !empty;
  assign bus.overflow = overflow_q;
  assign bus.d_out    = {!empty, overflow_q, 10'b0,
                         (!empty) ? mem[rd_ptr_q[AW-1:0]] : 4'b0};

endmodule

// File: tb/tb_keypad_input_port.sv
module tb_keypad_input_port;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  keypad_input_port_if #(.N_KEYS(4)) bus ();

  keypad_input_port #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_pulse();
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask

  // Press one key long enough to debounce, then release and let it settle.
  task automatic press_release(input logic [3:0] pat);
    bus.keys_n = pat;
    tick(8);
    bus.keys_n = 4'b1111;
    tick(8);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.keys_n = 4'b1111;
    bus.rd     = 1'b0;
    tick(3);
    reset = 1'b0;
    check("reset_dout", bus.d_out, 16'h0000);
    check("reset_valid", {15'b0, bus.valid}, 16'h0000);
    check("reset_ovf", {15'b0, bus.overflow}, 16'h0000);

    // 1. single press of key 1: stable at edge 6, pushed at edge 7
    bus.keys_n = 4'b1101;
    tick(6);
    check("t1_not_yet_valid", {15'b0, bus.valid}, 16'h0000);
    tick(1);
    check("t1_valid", {15'b0, bus.valid}, 16'h0001);
    check("t1_dout", bus.d_out, 16'h8001);
    read_pulse();
    check("t1_after_rd", bus.d_out, 16'h0000);
    bus.keys_n = 4'b1111;
    tick(10);
    check("t1_release_no_event", bus.d_out, 16'h0000);

    // 2. three-cycle glitch on key 0
    bus.keys_n = 4'b1110;
    tick(3);
    bus.keys_n = 4'b1111;
    tick(10);
    check("t2_glitch_dout", bus.d_out, 16'h0000);
    check("t2_glitch_valid", {15'b0, bus.valid}, 16'h0000);

    // 3. keys 3 and 0 together
    bus.keys_n = 4'b0110;
    tick(12);
    check("t3_first", bus.d_out, 16'h8000);
    read_pulse();
    check("t3_second", bus.d_out, 16'h8003);
    read_pulse();
    check("t3_empty", bus.d_out, 16'h0000);
    bus.keys_n = 4'b1111;
    tick(10);

    // 4. five presses of key 2, no reads
    for (int i = 0; i < 5; i++) press_release(4'b1011);
    check("t4_full_ovf", bus.d_out, 16'hC002);
    read_pulse();
    check("t4_rd1", bus.d_out, 16'h8002);
    read_pulse();
    check("t4_rd2", bus.d_out, 16'h8002);
    read_pulse();
    check("t4_rd3", bus.d_out, 16'h8002);
    read_pulse();
    check("t4_empty", bus.d_out, 16'h0000);

    // 5. fill with 0,1,2,3 then push key 0 on the same edge as a read
    press_release(4'b1110);
    press_release(4'b1101);
    press_release(4'b1011);
    press_release(4'b0111);
    check("t5_full_head", bus.d_out, 16'h8000);
    bus.keys_n = 4'b1110;
    tick(6);
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    check("t5_coincide", bus.d_out, 16'h8001);
    read_pulse();
    check("t5_rd2", bus.d_out, 16'h8002);
    read_pulse();
    check("t5_rd3", bus.d_out, 16'h8003);
    read_pulse();
    check("t5_rd4", bus.d_out, 16'h8000);
    read_pulse();
    check("t5_empty", bus.d_out, 16'h0000);
    bus.keys_n = 4'b1111;
    tick(10);

    // 6. reset mid-debounce with two entries queued
    press_release(4'b1011);
    press_release(4'b0111);
    check("t6_queued", bus.d_out, 16'h8002);
    bus.keys_n = 4'b1101;
    tick(4);
    #2 reset = 1'b1;
    #1;
    check("t6_reset_dout", bus.d_out, 16'h0000);
    check("t6_reset_valid", {15'b0, bus.valid}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(6);
    check("t6_redebounce_wait", {15'b0, bus.valid}, 16'h0000);
    tick(1);
    check("t6_redebounce", bus.d_out, 16'h8001);
    read_pulse();
    check("t6_single_event", bus.d_out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
